// File: rtl/rtc_pkg.sv
// Shared types and constants for the real-time-clock display path:
// FSM states, digit codes, active-low segment and anode patterns.
package rtc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADJ    = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  localparam int         DIGIT_W = 4;
  localparam logic [3:0] BLANK   = 4'hF;

  // Segment order is {g,f,e,d,c,b,a}, a lit segment is 0
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_D0  = 4'b1110;
  localparam logic [3:0] AN_D1  = 4'b1101;
  localparam logic [3:0] AN_D2  = 4'b1011;
  localparam logic [3:0] AN_D3  = 4'b0111;
  localparam logic [3:0] AN_OFF = 4'b1111;

  // Double-dabble correction step for one BCD nibble
  function automatic logic [3:0] adj3(input logic [3:0] n);
    logic [3:0] r;
    if (n >= 4'd5) begin
      r = n + 4'd3;
    end else begin
      r = n;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low 7-segment decoder; any code
// outside 0-9 (including BLANK) turns every segment off.
module seg7_decode
  import rtc_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [6:0]         seg
);

  // Digit lookup
  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/rtc_seg_display.sv
// Display stage of the real-time clock: snapshots seconds/minutes on each
// 1 Hz tick, converts seconds to BCD and scans a 4-digit 7-segment display.
module rtc_seg_display
  import rtc_pkg::*;
#(
  parameter int SCAN_DIV  = 125000,
  parameter int BLINK_DIV = 31250000
) (
  input  logic       clk_125MHz,
  input  logic       rst,
  input  logic       clk_1Hz,
  input  logic [5:0] count,
  input  logic [1:0] min,
  input  logic       done,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       busy
);

  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic               sync1_r, sync2_r, sync3_r, init_r;
  logic               req_s;
  state_e             state_r;
  logic [13:0]        shreg_r;
  logic [2:0]         shift_cnt_r;
  logic [1:0]         min_q_r;
  logic               pending_r;
  logic               busy_r;
  logic [DIGIT_W-1:0] d0_r, d1_r, d2_r, d3_r;
  logic [SCAN_W-1:0]  scan_cnt_r;
  logic [1:0]         idx_r;
  logic [BLINK_W-1:0] blink_cnt_r;
  logic               phase_r;
  logic [DIGIT_W-1:0] cur_digit_s;
  logic [3:0]         cur_an_s;
  logic [6:0]         cur_seg_s;
  logic [3:0]         an_r;
  logic [6:0]         seg_r;
  logic               dp_r;

  // init_r makes the first cycle out of reset look like a tick
  assign req_s = (sync2_r & ~sync3_r) | init_r;

  // Tick synchronizer and edge-detect history
  always_ff @(posedge clk_125MHz) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
      init_r  <= 1'b1;
    end else begin
      sync1_r <= clk_1Hz;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
      init_r  <= 1'b0;
    end
  end

  // Snapshot and shift-add-3 conversion FSM
  always_ff @(posedge clk_125MHz) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      shreg_r     <= 14'd0;
      shift_cnt_r <= 3'd0;
      min_q_r     <= 2'd0;
      pending_r   <= 1'b0;
      busy_r      <= 1'b0;
      d0_r        <= 4'd0;
      d1_r        <= 4'd0;
      d2_r        <= 4'd0;
      d3_r        <= 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_s || pending_r) begin
            shreg_r     <= {8'd0, count};
            min_q_r     <= min;
            shift_cnt_r <= 3'd0;
            pending_r   <= 1'b0;
            busy_r      <= 1'b1;
            state_r     <= ST_ADJ;
          end else begin
            busy_r      <= 1'b0;
          end
        end
        ST_ADJ: begin
          shreg_r <= {adj3(shreg_r[13:10]), adj3(shreg_r[9:6]), shreg_r[5:0]};
          if (req_s) pending_r <= 1'b1;
          state_r <= ST_SHIFT;
        end
        ST_SHIFT: begin
          shreg_r <= {shreg_r[12:0], 1'b0};
          if (req_s) pending_r <= 1'b1;
          if (shift_cnt_r == 3'd5) begin
            state_r <= ST_COMMIT;
          end else begin
            shift_cnt_r <= shift_cnt_r + 3'd1;
            state_r     <= ST_ADJ;
          end
        end
        ST_COMMIT: begin
          d0_r      <= shreg_r[9:6];
          d1_r      <= shreg_r[13:10];
          d2_r      <= {2'b00, min_q_r};
          d3_r      <= BLANK;
          // A pending tick keeps busy high straight into the next capture
          pending_r <= pending_r | req_s;
          busy_r    <= pending_r | req_s;
          state_r   <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Digit scan timer and index
  always_ff @(posedge clk_125MHz) begin
    if (rst) begin
      scan_cnt_r <= '0;
      idx_r      <= 2'd0;
    end else if (scan_cnt_r == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_r <= '0;
      idx_r      <= idx_r + 2'd1;
    end else begin
      scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
    end
  end

  // Blink phase timer, held clear whenever done is low
  always_ff @(posedge clk_125MHz) begin
    if (rst || !done) begin
      blink_cnt_r <= '0;
      phase_r     <= 1'b0;
    end else if (blink_cnt_r == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt_r <= '0;
      phase_r     <= ~phase_r;
    end else begin
      blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
    end
  end

  // Current digit and anode selection
  always_comb begin
    cur_digit_s = d0_r;
    cur_an_s    = AN_D0;
    case (idx_r)
      2'd0:    begin cur_digit_s = d0_r; cur_an_s = AN_D0; end
      2'd1:    begin cur_digit_s = d1_r; cur_an_s = AN_D1; end
      2'd2:    begin cur_digit_s = d2_r; cur_an_s = AN_D2; end
      2'd3:    begin cur_digit_s = d3_r; cur_an_s = AN_D3; end
      default: begin cur_digit_s = BLANK; cur_an_s = AN_OFF; end
    endcase
  end

  seg7_decode u_dec (
    .digit (cur_digit_s),
    .seg   (cur_seg_s)
  );

  // Registered display outputs
  always_ff @(posedge clk_125MHz) begin
    if (rst) begin
      an_r  <= AN_OFF;
      seg_r <= SEG_BLANK;
      dp_r  <= 1'b1;
    end else begin
      an_r  <= (done && phase_r) ? AN_OFF : cur_an_s;
      seg_r <= cur_seg_s;
      dp_r  <= (idx_r != 2'd2);
    end
  end

  assign an   = an_r;
  assign seg  = seg_r;
  assign dp   = dp_r;
  assign busy = busy_r;

endmodule

// File: tb/tb_rtc_seg_display.sv
// Scoreboard bench for rtc_seg_display: stimulus queues the expected
// digits, a monitor checks a full scan after every completed conversion.
module tb_rtc_seg_display;

  logic       clk_125MHz = 1'b0;
  logic       rst, clk_1Hz, done;
  logic [5:0] count;
  logic [1:0] min;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp, busy;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S9 = 7'b0010000,
                         SB = 7'b1111111;

  typedef struct packed { logic [6:0] s0, s1, s2; } exp_t;
  typedef struct { logic [5:0] c; logic [1:0] m; logic [6:0] s0, s1, s2; } vec_t;

  exp_t       exp_q[$];
  int         checks = 0, errors = 0, mon_count = 0;
  logic       prev_busy = 1'b0;
  logic [3:0] an_w  [20];
  logic [6:0] seg_w [20];
  logic       dp_w  [20];

  rtc_seg_display #(.SCAN_DIV(4), .BLINK_DIV(16)) dut (
    .clk_125MHz (clk_125MHz),
    .rst        (rst),
    .clk_1Hz    (clk_1Hz),
    .count      (count),
    .min        (min),
    .done       (done),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .busy       (busy)
  );

  always #4 clk_125MHz = ~clk_125MHz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every conversion that completes outside reset is checked over one scan
  initial begin
    forever begin
      @(negedge clk_125MHz);
      if (prev_busy && !busy && !rst) begin
        exp_t       e;
        logic [6:0] sl[4];
        logic       dl[4];
        logic       seen[4];
        logic [3:0] order[4];
        int         k, p;
        order = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        for (int i = 0; i < 4; i++) begin seen[i] = 1'b0; sl[i] = 7'd0; dl[i] = 1'b0; end
        for (int j = 0; j < 20; j++) begin
          @(negedge clk_125MHz);
          an_w[j] = an; seg_w[j] = seg; dp_w[j] = dp;
        end
        for (int j = 0; j < 20; j++) begin
          for (int i = 0; i < 4; i++) begin
            if (an_w[j] == order[i]) begin seen[i] = 1'b1; sl[i] = seg_w[j]; dl[i] = dp_w[j]; end
          end
        end
        if (exp_q.size() == 0) begin
          chk("unexpected_update", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          for (int i = 0; i < 4; i++) chk($sformatf("digit%0d_seen", i), {31'd0, seen[i]}, 32'd1);
          chk("seg_d0", {25'd0, sl[0]}, {25'd0, e.s0});
          chk("seg_d1", {25'd0, sl[1]}, {25'd0, e.s1});
          chk("seg_d2", {25'd0, sl[2]}, {25'd0, e.s2});
          chk("seg_d3_blank", {25'd0, sl[3]}, {25'd0, SB});
          chk("dp_d0", {31'd0, dl[0]}, 32'd1);
          chk("dp_d2", {31'd0, dl[2]}, 32'd0);
          chk("dp_d3", {31'd0, dl[3]}, 32'd1);
          // Scan order: after the first change, four runs of exactly four samples
          k = 0;
          for (int j = 1; j < 20; j++) if (k == 0 && an_w[j] != an_w[j-1]) k = j;
          p = -1;
          for (int i = 0; i < 4; i++) if (an_w[k] == order[i]) p = i;
          if (k == 0 || k > 4 || p < 0) begin
            chk("scan_order", 32'd0, 32'd1);
          end else begin
            logic ok;
            ok = 1'b1;
            for (int j = 0; j < 16; j++) if (an_w[k+j] != order[(p + j/4) % 4]) ok = 1'b0;
            chk("scan_order", {31'd0, ok}, 32'd1);
          end
        end
        mon_count++;
      end
      prev_busy = busy;
    end
  end

  task automatic busy_run(input int exp_len, input string name);
    int run;
    run = 0;
    for (int i = 0; i < 20 && run == 0; i++) begin
      @(negedge clk_125MHz);
      if (busy) run = 1;
    end
    if (run == 0) begin
      chk({name, "_start_timeout"}, 32'd0, 32'd1);
    end else begin
      for (int i = 0; i < 100; i++) begin
        @(negedge clk_125MHz);
        if (busy) run++;
        else break;
      end
      chk(name, run, exp_len);
    end
  endtask

  task automatic wait_mon(input int base, input string name);
    for (int i = 0; i < 100 && mon_count <= base; i++) @(negedge clk_125MHz);
    chk({name, "_monitor_seen"}, {31'd0, mon_count > base}, 32'd1);
  endtask

  task automatic push_exp(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c);
    exp_t e;
    e.s0 = a; e.s1 = b; e.s2 = c;
    exp_q.push_back(e);
  endtask

  task automatic pulse_1hz();
    clk_1Hz = 1'b1;
    @(negedge clk_125MHz);
    clk_1Hz = 1'b0;
  endtask

  // Directed stimulus
  initial begin
    vec_t vecs[4];
    int   base;
    logic off_w[80];
    vecs[0] = '{6'd37, 2'd2, S7, S3, S2};
    vecs[1] = '{6'd63, 2'd3, S3, S6, S3};
    vecs[2] = '{6'd0,  2'd0, S0, S0, S0};
    vecs[3] = '{6'd59, 2'd1, S9, S5, S1};

    rst = 1'b1; clk_1Hz = 1'b0; done = 1'b0; count = 6'd0; min = 2'd0;
    @(posedge clk_125MHz);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_125MHz);
      chk("reset_an", {28'd0, an}, 32'h0000000F);
      chk("reset_seg", {25'd0, seg}, {25'd0, SB});
      chk("reset_dp", {31'd0, dp}, 32'd1);
      chk("reset_busy", {31'd0, busy}, 32'd0);
    end
    push_exp(S0, S0, S0);
    base = mon_count;
    rst = 1'b0;
    busy_run(13, "busy_after_reset");
    wait_mon(base, "post_reset");

    for (int v = 0; v < 4; v++) begin
      count = vecs[v].c; min = vecs[v].m;
      push_exp(vecs[v].s0, vecs[v].s1, vecs[v].s2);
      base = mon_count;
      pulse_1hz();
      busy_run(13, $sformatf("busy_vec%0d", v));
      wait_mon(base, $sformatf("vec%0d", v));
    end

    // Back-to-back ticks five cycles apart; only the second value may settle
    count = 6'd10; min = 2'd0;
    push_exp(S1, S1, S0);
    base = mon_count;
    fork
      busy_run(27, "busy_back_to_back");
      begin
        pulse_1hz();
        @(negedge clk_125MHz);
        @(negedge clk_125MHz);
        count = 6'd11;
        @(negedge clk_125MHz);
        @(negedge clk_125MHz);
        pulse_1hz();
      end
    join
    wait_mon(base, "back_to_back");

    // Blink: 16 cycles scanning, 16 cycles dark, repeating
    done = 1'b1;
    for (int j = 0; j < 80; j++) begin
      @(negedge clk_125MHz);
      off_w[j] = (an == 4'b1111);
    end
    begin
      int i, r1, r2, r3;
      i = 0; r1 = 0; r2 = 0; r3 = 0;
      while (i < 80 && !off_w[i]) i++;
      while (i < 80 && off_w[i])  begin r1++; i++; end
      while (i < 80 && !off_w[i]) begin r2++; i++; end
      while (i < 80 && off_w[i])  begin r3++; i++; end
      chk("blink_off_run1", r1, 32'd16);
      chk("blink_on_run", r2, 32'd16);
      chk("blink_off_run2", r3, 32'd16);
    end
    for (int j = 0; j < 40 && an != 4'b1111; j++) @(negedge clk_125MHz);
    chk("blink_dark_before_release", {28'd0, an}, 32'h0000000F);
    done = 1'b0;
    @(negedge clk_125MHz);
    chk("blink_resume", {31'd0, an == 4'b1111}, 32'd0);

    // Reset during conversion, then a fresh conversion of the same inputs
    count = 6'd45; min = 2'd1;
    push_exp(S5, S4, S1);
    base = mon_count;
    pulse_1hz();
    for (int j = 0; j < 20 && !busy; j++) @(negedge clk_125MHz);
    chk("abort_busy_started", {31'd0, busy}, 32'd1);
    for (int j = 0; j < 5; j++) @(negedge clk_125MHz);
    rst = 1'b1;
    @(negedge clk_125MHz);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_an", {28'd0, an}, 32'h0000000F);
    chk("abort_seg", {25'd0, seg}, {25'd0, SB});
    chk("abort_dp", {31'd0, dp}, 32'd1);
    @(negedge clk_125MHz);
    rst = 1'b0;
    busy_run(13, "busy_after_abort");
    wait_mon(base, "after_abort");

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
